ram_loader: RTL and testbench
=============================

# ram_loader

Program loader and bus arbiter for the 16×8 CPU RAM. While idle it passes the CPU control word (mar_bus/mi, ram_bus/ri) straight through to the RAM. On a start request it halts the CPU, takes ownership of the RAM port and writes bytes from a valid/ready byte stream (UART receiver or front-panel switches) into addresses 0..load_last. Each byte is read back and verified. It sits between the control unit and the ram block.

## Interface
- AW, 4, RAM address width (depth 2^AW)
- DW, 8, RAM data width
- clk  in  1  system clock; all state changes on posedge
- clr  in  1  reset: synchronous, active-high
- start  in  1  begin load; sampled only in IDLE
- abort  in  1  cancel load or clear error; wins over start
- load_last  in  AW  address of final byte; latched on accepted start
- rx_data  in  DW  stream byte
- rx_valid  in  1  stream byte valid
- rx_ready  out  1  loader accepts byte this cycle
- cpu_mar_bus  in  AW  CPU address for MAR
- cpu_mi  in  1  CPU MAR-in strobe
- cpu_ram_bus  in  DW  CPU write data
- cpu_ri  in  1  CPU RAM-in strobe
- ram_value  in  DW  RAM read data (combinational from MAR)
- mar_bus  out  AW  to RAM
- mi  out  1  to RAM
- ram_bus  out  DW  to RAM
- ri  out  1  to RAM
- cpu_halt  out  1  CPU clock-enable gate; high whenever state ≠ IDLE
- busy  out  1  state ∈ {WAIT_BYTE, SET_ADDR, WRITE, VERIFY}
- done  out  1  one-cycle pulse on successful completion
- error  out  1  verify mismatch; sticky
- err_addr  out  AW  address of the failing byte

## Operation
- Reset values: state IDLE, addr 0, last 0, data_q 0, done 0, error 0, err_addr 0, rx_ready 0, cpu_halt 0; RAM outputs follow the CPU inputs.
- States:
  - IDLE
    - Outputs are the CPU signals, unmodified.
    - start & !abort → latch last=load_last, addr=0 → WAIT_BYTE.
  - WAIT_BYTE
    - rx_ready=1.
    - rx_valid → latch data_q=rx_data → SET_ADDR.
  - SET_ADDR
    - mar_bus=addr, mi=1, ri=0.
    - → WRITE.
  - WRITE
    - ram_bus=data_q, ri=1, mi=0.
    - → VERIFY.
  - VERIFY
    - mi=ri=0.
    - ram_value≠data_q → err_addr=addr, error=1 → ERROR.
    - Else if addr==last → DONE.
    - Else addr+1 → WAIT_BYTE.
  - DONE
    - done=1, cpu_halt=1.
    - → IDLE.
  - ERROR
    - mi=ri=0, cpu_halt=1.
    - Holds until abort.
    - abort → error=0 → IDLE.
- In every non-IDLE state, CPU strobes are ignored (never forwarded). Loader-owned outputs not listed above drive 0.
- abort in any non-IDLE state → IDLE on the next edge. Bytes already written stay written; no partial-load flag.
- start while not IDLE is ignored.
- load_last=0 loads exactly one byte; load_last=2^AW−1 fills the whole RAM. addr never wraps.
- clr mid-load → IDLE next edge, same as reset. The RAM keeps its contents.

## Timing
- Accepted start at edge 0: WAIT_BYTE during cycle 1.
- Per byte: 4 cycles minimum (accept, SET_ADDR, WRITE, VERIFY). MAR is updated at the end of SET_ADDR and the write lands at the end of WRITE, so ram_value is valid in VERIFY.
- Full 16-byte load with rx_valid held high: done high in cycle 65, IDLE in cycle 66.
- Any rx_valid gap adds cycles only in WAIT_BYTE.
- rx_ready is registered-state decoded. No combinational path from rx_valid to rx_ready.
- RAM-side outputs are combinational muxes of the state register and CPU inputs. In IDLE, cpu_* → RAM is zero-latency.
- cpu_halt asserts in the first cycle after start is accepted and drops in the cycle after DONE.

## Structure
- Package ram_loader_pkg:
  - state enum: IDLE, WAIT_BYTE, SET_ADDR, WRITE, VERIFY, DONE, ERROR
  - default AW/DW constants
- One sub-module, ram_bus_mux: purely combinational selection of CPU versus loader drive for mar_bus/mi/ram_bus/ri, controlled by an owner bit.
- The FSM, address counter and verify compare live in ram_loader.

## Test plan
- Full load: load_last=15, rx_valid constant, bytes 0x10..0x1F → RAM[i]=0x10+i, done pulse at cycle 65, error=0, cpu_halt low from cycle 66.
- Backpressure: load_last=3, rx_valid gaps of 0/2/5 cycles → rx_ready high only in WAIT_BYTE, no byte lost or duplicated, RAM[0..3] correct.
- Verify fail: RAM model stuck bit 0 at address 5 → error=1, err_addr=5, loader in ERROR, mi=ri=0. abort → IDLE, error=0.
- Abort/reset mid-load: abort after byte 7 accepted → IDLE next edge, cpu_halt=0, RAM[0..6] written, no done. Repeat using clr → same result.
- Pass-through: IDLE with cpu_mi=1, cpu_mar_bus=0xA, then cpu_ri=1, cpu_ram_bus=0x5C → RAM[10]=0x5C. During a load, the same CPU strobes produce no effect.
- Start edge cases: start asserted while busy → ignored. start&abort in IDLE → stays IDLE. load_last=0 → one byte written, done after 5 cycles.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and default geometry for the RAM program loader.
// The state encoding is shared so the loader and any debug tap agree on it.
package ram_loader_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SET_ADDR,
        WRITE,
        VERIFY,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/ram_bus_mux.sv
// Selects who drives the RAM control word: the CPU control unit or the loader.
// Purely combinational so the CPU path stays zero-latency while the loader is idle.
module ram_bus_mux
    import ram_loader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          owner,
    input  logic [AW-1:0] cpu_mar_bus,
    input  logic          cpu_mi,
    input  logic [DW-1:0] cpu_ram_bus,
    input  logic          cpu_ri,
    input  logic [AW-1:0] ld_mar_bus,
    input  logic          ld_mi,
    input  logic [DW-1:0] ld_ram_bus,
    input  logic          ld_ri,
    output logic [AW-1:0] mar_bus,
    output logic          mi,
    output logic [DW-1:0] ram_bus,
    output logic          ri
);

    always_comb begin
        mar_bus = cpu_mar_bus;
        mi      = cpu_mi;
        ram_bus = cpu_ram_bus;
        ri      = cpu_ri;
        if (owner) begin
            mar_bus = ld_mar_bus;
            mi      = ld_mi;
            ram_bus = ld_ram_bus;
            ri      = ld_ri;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Program loader and RAM bus arbiter: halts the CPU, streams bytes into RAM
// addresses 0..load_last and reads each one back before moving on.
//
// state     | meaning
// IDLE      | CPU owns the RAM port, waiting for start
// WAIT_BYTE | rx_ready high, waiting for the next stream byte
// SET_ADDR  | load MAR with the current address
// WRITE     | write the captured byte into RAM
// VERIFY    | compare RAM read-back against the captured byte
// DONE      | one-cycle completion pulse
// ERROR     | read-back mismatch, held until abort
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] load_last,
    input  logic [DW-1:0] rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic [AW-1:0] cpu_mar_bus,
    input  logic          cpu_mi,
    input  logic [DW-1:0] cpu_ram_bus,
    input  logic          cpu_ri,
    input  logic [DW-1:0] ram_value,
    output logic [AW-1:0] mar_bus,
    output logic          mi,
    output logic [DW-1:0] ram_bus,
    output logic          ri,
    output logic          cpu_halt,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_addr
);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] last_q, last_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    logic [AW-1:0] ld_mar_bus;
    logic          ld_mi;
    logic [DW-1:0] ld_ram_bus;
    logic          ld_ri;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            data_q     <= data_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        data_d     = data_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        ld_mar_bus = '0;
        ld_mi      = 1'b0;
        ld_ram_bus = '0;
        ld_ri      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    last_d  = load_last;
                    addr_d  = '0;
                    state_d = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (rx_valid) begin
                    data_d  = rx_data;
                    state_d = SET_ADDR;
                end
            end
            SET_ADDR: begin
                ld_mar_bus = addr_q;
                ld_mi      = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                ld_ram_bus = data_q;
                ld_ri      = 1'b1;
                state_d    = VERIFY;
            end
            VERIFY: begin
                if (ram_value != data_q) begin
                    err_addr_d = addr_q;
                    err_d      = 1'b1;
                    state_d    = ERROR;
                end else if (addr_q == last_q) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = WAIT_BYTE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERROR: begin
                if (abort) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort beats everything outside IDLE, including a same-cycle verify failure.
        if (abort && (state_q != IDLE)) begin
            err_d   = 1'b0;
            state_d = IDLE;
        end
    end

    ram_bus_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .owner      (state_q != IDLE),
        .cpu_mar_bus(cpu_mar_bus),
        .cpu_mi     (cpu_mi),
        .cpu_ram_bus(cpu_ram_bus),
        .cpu_ri     (cpu_ri),
        .ld_mar_bus (ld_mar_bus),
        .ld_mi      (ld_mi),
        .ld_ram_bus (ld_ram_bus),
        .ld_ri      (ld_ri),
        .mar_bus    (mar_bus),
        .mi         (mi),
        .ram_bus    (ram_bus),
        .ri         (ri)
    );

    assign rx_ready = (state_q == WAIT_BYTE);
    assign cpu_halt = (state_q != IDLE);
    assign busy     = (state_q inside {WAIT_BYTE, SET_ADDR, WRITE, VERIFY});
    assign done     = (state_q == DONE);
    assign error    = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: stimulus queues expected RAM writes and done
// cycles, a negedge monitor pops them as the DUT writes RAM or pulses done.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       clr, start, abort;
    logic [3:0] load_last;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [3:0] cpu_mar_bus;
    logic       cpu_mi;
    logic [7:0] cpu_ram_bus;
    logic       cpu_ri;
    logic [7:0] ram_value;
    logic [3:0] mar_bus;
    logic       mi;
    logic [7:0] ram_bus;
    logic       ri;
    logic       cpu_halt, busy, done, error;
    logic [3:0] err_addr;

    always #5 clk = ~clk;

    ram_loader dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .abort      (abort),
        .load_last  (load_last),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .cpu_mar_bus(cpu_mar_bus),
        .cpu_mi     (cpu_mi),
        .cpu_ram_bus(cpu_ram_bus),
        .cpu_ri     (cpu_ri),
        .ram_value  (ram_value),
        .mar_bus    (mar_bus),
        .mi         (mi),
        .ram_bus    (ram_bus),
        .ri         (ri),
        .cpu_halt   (cpu_halt),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_addr   (err_addr)
    );

    // RAM model with a MAR register and an optional stuck-at-0 bit 0 at address 5.
    logic [7:0] mem [16];
    logic [3:0] mar_m = 4'h0;
    logic       stuck = 1'b0;
    logic       ram_wipe = 1'b0;

    always @(posedge clk) begin
        if (ram_wipe) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            mar_m <= 4'h0;
        end else begin
            if (mi) mar_m <= mar_bus;
            if (ri) mem[mar_m] <= ram_bus;
        end
    end

    assign ram_value = (stuck && mar_m == 4'd5) ? (mem[mar_m] & 8'hFE) : mem[mar_m];

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  rdy_cnt = 0;
    int  rdy0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        wr_t e;
        int  ed;
        if (ri) begin
            chk("write_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                chk("ram_write_addr_data", 32'({mar_m, ram_bus}), 32'(e));
            end
        end
        if (done) begin
            chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
            if (exp_done.size() != 0) begin
                ed = exp_done.pop_front();
                chk("done_cycle", 32'(cyc - start_cyc + 1), 32'(ed));
            end
        end
        if (rx_ready) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic push_wr(input logic [3:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    task automatic start_load(input logic [3:0] last);
        rx_valid  = 1'b0;
        load_last = last;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        rdy0      = rdy_cnt;
    endtask

    // Waits for WAIT_BYTE, idles rx_valid for gap cycles there, then hands over d.
    task automatic send_byte(input logic [7:0] d, input int gap);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_ready && n < 100);
        chk("rx_ready_seen", 32'(rx_ready), 32'd1);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        chk("done_seen", 32'(done), 32'd1);
        chk("halt_in_done", 32'(cpu_halt), 32'd1);
        chk("error_after_load", 32'(error), 32'd0);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("halt_released", 32'(cpu_halt), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic wipe_ram();
        ram_wipe = 1'b1;
        @(posedge clk);
        #1;
        ram_wipe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int gaps [4];
        gaps = '{0, 2, 5, 0};
        clr = 1'b1; start = 1'b0; abort = 1'b0; load_last = 4'h0;
        rx_data = 8'h00; rx_valid = 1'b0;
        cpu_mar_bus = 4'h0; cpu_mi = 1'b0; cpu_ram_bus = 8'h00; cpu_ri = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        chk("rst_cpu_halt", 32'(cpu_halt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_mi_ri", 32'({mi, ri}), 32'd0);
        @(posedge clk);
        #1;
        wipe_ram();

        // Pass-through in IDLE
        cpu_mar_bus = 4'hA; cpu_mi = 1'b1;
        @(negedge clk);
        chk("pt_mar_bus", 32'(mar_bus), 32'hA);
        chk("pt_mi", 32'(mi), 32'd1);
        @(posedge clk);
        #1;
        cpu_mi = 1'b0; cpu_ram_bus = 8'h5C; cpu_ri = 1'b1;
        push_wr(4'hA, 8'h5C);
        @(negedge clk);
        chk("pt_ram_bus", 32'(ram_bus), 32'h5C);
        @(posedge clk);
        #1;
        cpu_ri = 1'b0;
        @(negedge clk);
        chk("pt_mem10", 32'(mem[10]), 32'h5C);

        // Full 16-byte load, rx_valid effectively continuous
        exp_done.push_back(65);
        start_load(4'hF);
        for (int i = 0; i < 16; i++) begin
            push_wr(4'(i), 8'(8'h10 + i));
            send_byte(8'(8'h10 + i), 0);
        end
        wait_done();
        chk("full_rdy_cycles", 32'(rdy_cnt - rdy0), 32'd16);
        for (int i = 0; i < 16; i++) chk("full_mem", 32'(mem[i]), 32'(16 + i));

        // CPU strobes ignored during load; start while busy ignored
        exp_done.push_back(9);
        start_load(4'h1);
        cpu_mar_bus = 4'hF; cpu_mi = 1'b1; cpu_ram_bus = 8'hEE; cpu_ri = 1'b1;
        start = 1'b1; load_last = 4'h5;
        push_wr(4'h0, 8'hA0);
        send_byte(8'hA0, 0);
        start = 1'b0;
        push_wr(4'h1, 8'hA1);
        send_byte(8'hA1, 0);
        @(negedge clk);
        chk("own_set_addr", 32'({mar_bus, mi, ri}), 32'({4'h1, 1'b1, 1'b0}));
        @(negedge clk);
        chk("own_write", 32'({ram_bus, mi, ri}), 32'({8'hA1, 1'b0, 1'b1}));
        cpu_mi = 1'b0; cpu_ri = 1'b0;
        wait_done();
        chk("own_mem0", 32'(mem[0]), 32'hA0);
        chk("own_mem1", 32'(mem[1]), 32'hA1);
        chk("own_mem15", 32'(mem[15]), 32'h1F);

        // Backpressure with rx_valid gaps of 0/2/5/0 cycles
        exp_done.push_back(24);
        start_load(4'h3);
        for (int i = 0; i < 4; i++) begin
            push_wr(4'(i), 8'(8'h30 + i));
            send_byte(8'(8'h30 + i), gaps[i]);
        end
        wait_done();
        chk("bp_rdy_cycles", 32'(rdy_cnt - rdy0), 32'd11);
        for (int i = 0; i < 4; i++) chk("bp_mem", 32'(mem[i]), 32'(48 + i));

        // Single byte load
        exp_done.push_back(5);
        start_load(4'h0);
        push_wr(4'h0, 8'h77);
        send_byte(8'h77, 0);
        wait_done();
        chk("one_mem0", 32'(mem[0]), 32'h77);
        chk("one_mem1", 32'(mem[1]), 32'h31);

        // start and abort together in IDLE
        load_last = 4'h3; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("sa_halt", 32'(cpu_halt), 32'd0);
        chk("sa_rx_ready", 32'(rx_ready), 32'd0);

        // Verify failure at address 5
        stuck = 1'b1;
        start_load(4'h7);
        for (int i = 0; i < 6; i++) begin
            push_wr(4'(i), 8'(8'h20 + i));
            send_byte(8'(8'h20 + i), 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("vf_error", 32'(error), 32'd1);
        chk("vf_err_addr", 32'(err_addr), 32'd5);
        chk("vf_halt", 32'(cpu_halt), 32'd1);
        chk("vf_busy", 32'(busy), 32'd0);
        chk("vf_mi_ri", 32'({mi, ri}), 32'd0);
        repeat (4) @(negedge clk);
        chk("vf_sticky", 32'({error, rx_ready}), 32'({1'b1, 1'b0}));
        @(posedge clk);
        #1;
        abort = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("vf_abort_error", 32'(error), 32'd0);
        chk("vf_abort_halt", 32'(cpu_halt), 32'd0);
        stuck = 1'b0;

        // Abort after byte 7 accepted
        wipe_ram();
        start_load(4'hF);
        for (int i = 0; i < 8; i++) begin
            if (i < 7) push_wr(4'(i), 8'(8'h40 + i));
            send_byte(8'(8'h40 + i), 0);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        chk("ab_halt", 32'(cpu_halt), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 7; i++) chk("ab_mem", 32'(mem[i]), 32'(64 + i));
        chk("ab_mem7", 32'(mem[7]), 32'd0);

        // Same with clr
        wipe_ram();
        start_load(4'hF);
        for (int i = 0; i < 8; i++) begin
            if (i < 7) push_wr(4'(i), 8'(8'h50 + i));
            send_byte(8'(8'h50 + i), 0);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        chk("clr_halt", 32'(cpu_halt), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_err_addr", 32'(err_addr), 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 7; i++) chk("clr_mem", 32'(mem[i]), 32'(80 + i));
        chk("clr_mem7", 32'(mem[7]), 32'd0);

        repeat (3) @(negedge clk);
        chk("write_queue_drained", 32'(exp_wr.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_done.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
